ef_gpio8_seq: RTL and testbench
===============================

# ef_gpio8_seq

Output-direction companion to the GPIO8 input path: a timed output sequencer that drives the 8-bit GPIO output bus from a queue of (value, hold-time) entries. Software or a bus wrapper pushes entries into an internal FIFO. The sequencer pops each entry, drives its value on `io_out` for the programmed number of prescaled ticks, then moves to the next entry with no gap. It sits between the bus register file and the pad-side `io_out`/`io_oe` nets.

## Interface
Parameters:
- `AW`, 3: FIFO address width; depth = 2**AW entries.
- `HW`, 16: hold-count width in ticks.
- `INIT`, 8'h00: value of `io_out` after reset.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sequencer enable; when 0, the prescaler and hold counter freeze.
- `prescale`  in  8  tick period = `prescale`+1 clk cycles.
- `flush`  in  1  synchronous abort: empties the FIFO and returns to IDLE.
- `wr`  in  1  push strobe.
- `wdata`  in  8+HW  entry: {hold[HW-1:0], value[7:0]}.
- `bus_oe`  in  8  output-enable from the register file.
- `io_out`  out  8  registered pad output value.
- `io_oe`  out  8  registered copy of `bus_oe`, aligned to `io_out`.
- `full`, `empty`  out  1  FIFO status.
- `level`  out  AW+1  FIFO occupancy, 0..2**AW.
- `busy`  out  1  1 while in the HOLD state.
- `done`  out  1  one-cycle pulse when the sequence drains to IDLE.
- `wr_drop`  out  1  one-cycle pulse when a push is rejected.

## Operation
- FIFO:
  - Holds 2**AW entries.
  - A push with `wr`=1 and `full`=0 is accepted. A push with `full`=1 is dropped, and `wr_drop` pulses on the next cycle.
  - A push into a full FIFO is dropped even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-empty, non-full FIFO leaves `level` unchanged.
- FSM has two states, IDLE and HOLD.
  - IDLE, with `en`=1 and `empty`=0: pop the head entry, load `io_out`<=value and `cnt`<=max(hold,1), clear the prescaler, go to HOLD.
  - HOLD, on a tick with `cnt`>1: decrement `cnt`.
  - HOLD, on a tick with `cnt`==1 and the FIFO non-empty: pop and load the next entry in the same edge (seamless), stay in HOLD.
  - HOLD, on a tick with `cnt`==1 and the FIFO empty: go to IDLE and pulse `done`.
- Hold encoding: hold=0 is treated as 1.
- `io_out` holds its last value in IDLE; the sequencer never returns to `INIT` on its own.
- Prescaler:
  - `pcnt` counts 0..`prescale`.
  - A tick occurs in any cycle with `en`=1 and `pcnt`==`prescale`; `pcnt` then wraps to 0.
  - `pcnt` is cleared on every entry load.
  - `prescale`=0 gives a tick every cycle.
- `en`=0: state, `cnt`, `pcnt` and `io_out` all freeze. Pushes are still accepted. Counting resumes exactly where it stopped.
- `flush`:
  - Takes priority over a push and over an FSM pop in the same cycle.
  - Resets the FIFO pointers and level, forces IDLE, and retains `io_out`.
  - Does not pulse `done`.
- `io_oe` is registered from `bus_oe` every cycle, independent of `en`.
- Reset (asynchronous, mid-operation allowed) sets:
  - `io_out`=`INIT`, `io_oe`=0, IDLE, `cnt`=0, `pcnt`=0;
  - `empty`=1, `full`=0, `level`=0;
  - `busy`=`done`=`wr_drop`=0.

## Timing
- Push latency: with `wr` sampled at edge k into an empty FIFO, IDLE, `en`=1, `empty` falls after k, the pop occurs at k+1, and `io_out`/`busy` update after edge k+1.
- Each entry drives `io_out` for exactly max(hold,1)×(`prescale`+1) clk cycles when `en` stays high.
- Back-to-back entries: `io_out` changes on the tick edge with zero idle cycles between entries.
- `done` is high in the single cycle after the final tick edge, while `busy`=0.
- A push and the final tick in the same cycle: the FIFO is still empty at that edge, so the FSM goes to IDLE and pulses `done`. The new entry loads one cycle later.

## Test plan
- Reset, then prescale=0, push {hold=3, 8'hA5}: `io_out`=A5 from edge k+1 for exactly 3 cycles. `done` pulses once and `io_out` stays A5.
- prescale=4, push {2,8'h01},{1,8'h02},{0,8'h03}: `io_out` holds 01 for 10 cycles, 02 for 5, and 03 for 5 (hold 0 treated as 1), with no gaps, then `done`.
- Push 9 entries with AW=3 while `en`=0: `full`=1 and `level`=8 after the 8th push. The 9th push raises `wr_drop` for 1 cycle and `level` stays 8.
- During HOLD with prescale=2 and hold=4, drop `en` for 7 cycles after the 2nd tick: total hold time = 12+7 cycles, and `io_out` is unchanged while `en`=0.
- Assert `flush` mid-HOLD with 3 entries queued: `empty`=1, `busy`=0 and `done`=0 next cycle, and `io_out` keeps its current value.
- Assert `rst` mid-HOLD, asynchronously between edges: all outputs immediately take their reset values (`io_out`=`INIT`, `io_oe`=0, `empty`=1).

Source files
------------

// File: rtl/ef_gpio8_seq.sv
// Timed GPIO output sequencer: pops (value, hold) entries from a small FIFO and
// drives each value on io_out for max(hold,1) prescaled ticks, back to back.
module ef_gpio8_seq #(
    parameter int         AW   = 3,
    parameter int         HW   = 16,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      prescale,
    input  logic            flush,
    input  logic            wr,
    input  logic [8+HW-1:0] wdata,
    input  logic [7:0]      bus_oe,
    output logic [7:0]      io_out,
    output logic [7:0]      io_oe,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     level,
    output logic            busy,
    output logic            done,
    output logic            wr_drop
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    logic [8+HW-1:0]   mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [HW-1:0]     cnt;
    logic [7:0]        pcnt;
    logic              tick;
    logic              last;
    logic              push;
    logic              pop;
    logic [7:0]        head_val;
    logic [HW-1:0]     head_hold;
    logic [HW-1:0]     head_cnt;

    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign tick      = en && (pcnt == prescale);
    assign last      = (cnt == HW'(1));
    assign head_val  = mem[rptr][7:0];
    assign head_hold = mem[rptr][8+HW-1:8];
    assign head_cnt  = (head_hold == '0) ? HW'(1) : head_hold;

    // flush outranks both FIFO ports; a full FIFO rejects a push even when popping
    assign push = wr && !full && !flush;
    assign pop  = !flush && en && !empty &&
                  ((state == IDLE) || ((state == HOLD) && tick && last));

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr && full;
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                case ({push, pop})
                    2'b10:   level <= level + (AW+1)'(1);
                    2'b01:   level <= level - (AW+1)'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) io_oe <= '0;
        else     io_oe <= bus_oe;
    end

    // Sequencer: everything but done is frozen while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pcnt   <= '0;
            io_out <= INIT;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
                pcnt  <= '0;
            end else if (en) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            io_out <= head_val;
                            cnt    <= head_cnt;
                            pcnt   <= '0;
                            state  <= HOLD;
                            busy   <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!tick) begin
                            pcnt <= pcnt + 8'(1);
                        end else if (!last) begin
                            cnt  <= cnt - HW'(1);
                            pcnt <= '0;
                        end else if (pop) begin
                            io_out <= head_val;
                            cnt    <= head_cnt;
                            pcnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            cnt   <= '0;
                            pcnt  <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ef_gpio8_seq.sv
// Directed bench for ef_gpio8_seq: hand-computed hold durations, FIFO limits,
// enable freeze, flush and asynchronous reset.
module tb_ef_gpio8_seq;

    localparam int AW = 3;
    localparam int HW = 16;

    logic            clk;
    logic            rst;
    logic            en;
    logic [7:0]      prescale;
    logic            flush;
    logic            wr;
    logic [8+HW-1:0] wdata;
    logic [7:0]      bus_oe;
    logic [7:0]      io_out;
    logic [7:0]      io_oe;
    logic            full;
    logic            empty;
    logic [AW:0]     level;
    logic            busy;
    logic            done;
    logic            wr_drop;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    ef_gpio8_seq #(.AW(AW), .HW(HW), .INIT(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .prescale(prescale), .flush(flush),
        .wr(wr), .wdata(wdata), .bus_oe(bus_oe), .io_out(io_out), .io_oe(io_oe),
        .full(full), .empty(empty), .level(level), .busy(busy), .done(done),
        .wr_drop(wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] value, input logic [HW-1:0] hold);
        wr    = 1'b1;
        wdata = {hold, value};
        step();
        wr    = 1'b0;
    endtask

    int busy_n, done_n, bad_n, gap_n, c1, c2, c3, first_busy;

    initial begin
        rst = 1'b1; en = 1'b0; prescale = 8'd0; flush = 1'b0;
        wr = 1'b0; wdata = '0; bus_oe = 8'h00;
        step(); step();
        check("rst_io_out", io_out, 8'h00);
        check("rst_io_oe", io_oe, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_drop", wr_drop, 0);
        rst = 1'b0;
        step();

        // single entry, hold 3, prescale 0
        en = 1'b1; prescale = 8'd0;
        push(8'hA5, 16'd3);
        check("t1_empty_after_push", empty, 0);
        check("t1_level_after_push", level, 1);
        check("t1_busy_before_pop", busy, 0);
        busy_n = 0; done_n = 0; bad_n = 0; first_busy = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) begin
                if (first_busy < 0) first_busy = i;
                busy_n++;
                if (io_out !== 8'hA5) bad_n++;
            end
            if (done) begin
                done_n++;
                if (busy) bad_n++;
            end
        end
        check("t1_first_busy_cycle", first_busy, 0);
        check("t1_hold_cycles", busy_n, 3);
        check("t1_bad_cycles", bad_n, 0);
        check("t1_done_pulses", done_n, 1);
        check("t1_io_out_retained", io_out, 8'hA5);

        // three entries, prescale 4, hold 2/1/0
        en = 1'b0; prescale = 8'd4;
        push(8'h01, 16'd2);
        push(8'h02, 16'd1);
        push(8'h03, 16'd0);
        check("t2_level", level, 3);
        en = 1'b1;
        c1 = 0; c2 = 0; c3 = 0; gap_n = 0; done_n = 0; first_busy = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy) begin
                if (first_busy < 0) first_busy = i;
                if (io_out === 8'h01) c1++;
                if (io_out === 8'h02) c2++;
                if (io_out === 8'h03) c3++;
            end else if (first_busy >= 0 && done_n == 0 && !done) begin
                gap_n++;
            end
            if (done) done_n++;
        end
        check("t2_hold_01", c1, 10);
        check("t2_hold_02", c2, 5);
        check("t2_hold_03", c3, 5);
        check("t2_gaps", gap_n, 0);
        check("t2_done_pulses", done_n, 1);
        check("t2_io_out_end", io_out, 8'h03);

        // fill while disabled, overflow, then drain in order
        en = 1'b0; prescale = 8'd0; bus_oe = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            push(8'h10 + 8'(i), 16'd1);
            exp_q.push_back(8'h10 + 8'(i));
        end
        check("t3_full", full, 1);
        check("t3_level8", level, 8);
        check("t3_no_drop_yet", wr_drop, 0);
        check("t3_io_oe", io_oe, 8'h3C);
        push(8'hFF, 16'd1);
        check("t3_wr_drop", wr_drop, 1);
        check("t3_level_kept", level, 8);
        step();
        check("t3_wr_drop_clear", wr_drop, 0);
        check("t3_io_out_frozen", io_out, 8'h03);
        en = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy) begin
                busy_n++;
                if (exp_q.size() > 0) check("t3_order", io_out, exp_q.pop_front());
            end
        end
        check("t3_drain_cycles", busy_n, 8);
        check("t3_queue_left", exp_q.size(), 0);

        // enable freeze after second tick: prescale 2, hold 4
        prescale = 8'd2;
        push(8'h5A, 16'd4);
        busy_n = 0; bad_n = 0; done_n = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (busy) busy_n++;
        end
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (busy) busy_n++;
            if (io_out !== 8'h5A) bad_n++;
            if (done) done_n++;
        end
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) busy_n++;
            if (done) done_n++;
        end
        check("t4_total_hold", busy_n, 19);
        check("t4_frozen_io_out", bad_n, 0);
        check("t4_done_pulses", done_n, 1);

        // flush mid-hold with 3 entries queued, concurrent push dropped
        en = 1'b0; prescale = 8'd0;
        push(8'h11, 16'd5);
        push(8'h22, 16'd5);
        push(8'h33, 16'd5);
        push(8'h44, 16'd5);
        en = 1'b1;
        step();
        check("t5_busy", busy, 1);
        check("t5_io_out", io_out, 8'h11);
        check("t5_level3", level, 3);
        step(); step();
        flush = 1'b1; wr = 1'b1; wdata = {16'd1, 8'h99};
        step();
        flush = 1'b0; wr = 1'b0;
        check("t5_empty", empty, 1);
        check("t5_level0", level, 0);
        check("t5_busy0", busy, 0);
        check("t5_done0", done, 0);
        check("t5_io_out_kept", io_out, 8'h11);
        step();
        check("t5_stays_idle", busy, 0);
        check("t5_no_done", done, 0);

        // asynchronous reset mid-hold
        bus_oe = 8'hF0;
        push(8'hC3, 16'd10);
        step();
        check("t6_busy", busy, 1);
        check("t6_io_out", io_out, 8'hC3);
        check("t6_io_oe", io_oe, 8'hF0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_io_out", io_out, 8'h00);
        check("t6_rst_io_oe", io_oe, 8'h00);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        #2 rst = 1'b0;
        step();
        check("t6_post_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
